// File: rtl/spi_pkg.sv
// Shared definitions for the SPI shift engine: FSM encodings, mode bit layout
// and the default bus widths.
package spi_pkg;

    localparam int FIFO_WIDTH_DEF = 32;
    localparam int DIV_WIDTH_DEF  = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LOAD  = 3'd2;
    localparam logic [2:0] ST_SHIFT = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_GAP   = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        FETCH = ST_FETCH,
        LOAD  = ST_LOAD,
        SHIFT = ST_SHIFT,
        DONE  = ST_DONE,
        GAP   = ST_GAP
    } state_t;

    localparam int MODE_CPOL = 1;
    localparam int MODE_CPHA = 0;

    // Index of the final (CS hold) half-period of a word, i.e. 2N for N = word_size+1.
    function automatic logic [6:0] last_half(input logic [4:0] word_size);
        return {1'b0, word_size, 1'b0} + 7'd2;
    endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period tick generator: one-cycle half_tick every div+1 cycles while run is high,
// with the first tick arriving div+1 cycles after run rises.
module spi_baud_gen
    import spi_pkg::*;
#(
    parameter int DIVWIDTH = DIV_WIDTH_DEF
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic                run,
    input  logic [DIVWIDTH-1:0] div,
    output logic                half_tick
);

    logic [DIVWIDTH-1:0] count;
    logic                active;
    logic [DIVWIDTH-1:0] remaining;

    // On the first cycle of a run the counter is still parked at zero, so the
    // reload value stands in for it.
    assign remaining = active ? count : div;
    assign half_tick = run && (remaining == '0);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count  <= '0;
            active <= 1'b0;
        end else if (!run) begin
            count  <= '0;
            active <= 1'b0;
        end else begin
            active <= 1'b1;
            count  <= (remaining == '0) ? div : remaining - DIVWIDTH'(1);
        end
    end

endmodule

// File: rtl/spi_shift_engine.sv
// SPI master serializer: pops TX FIFO words, shifts them out MSB-first with
// CPOL/CPHA framing and pushes the sampled MISO word into the RX FIFO.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int FIFOWIDTH = FIFO_WIDTH_DEF,
    parameter int DIVWIDTH  = DIV_WIDTH_DEF
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Enable,
    input  logic                 Cpol,
    input  logic                 Cpha,
    input  logic [4:0]           WordSize,
    input  logic [DIVWIDTH-1:0]  BaudDiv,
    input  logic                 TxEmpty,
    input  logic [FIFOWIDTH-1:0] TxData,
    output logic                 TxRead,
    input  logic                 RxFull,
    output logic [FIFOWIDTH-1:0] RxData,
    output logic                 RxWrite,
    input  logic                 ClearOV,
    output logic                 RxOV,
    output logic                 SCLK,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic                 CS_n,
    output logic                 Busy
);

    state_t               state;
    logic [FIFOWIDTH-1:0] tx_word;
    logic [FIFOWIDTH-1:0] rx_shift;
    logic [1:0]           mode_l;
    logic [4:0]           word_l;
    logic [DIVWIDTH-1:0]  div_l;
    logic [4:0]           bit_idx;
    logic [6:0]           half_cnt;
    logic [6:0]           last_idx;
    logic                 phase;
    logic                 half_tick;
    logic                 run;
    logic                 odd_edge;

    assign run      = (state == SHIFT) || (state == GAP);
    assign last_idx = last_half(word_l);
    assign odd_edge = ~half_cnt[0];
    assign SCLK     = ((state == SHIFT) ? mode_l[MODE_CPOL] : Cpol) ^ phase;

    spi_baud_gen #(
        .DIVWIDTH(DIVWIDTH)
    ) u_baud (
        .Clock    (Clock),
        .Reset    (Reset),
        .run      (run),
        .div      (div_l),
        .half_tick(half_tick)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            TxRead   <= 1'b0;
            RxWrite  <= 1'b0;
            RxData   <= '0;
            RxOV     <= 1'b0;
            CS_n     <= 1'b1;
            MOSI     <= 1'b0;
            Busy     <= 1'b0;
            phase    <= 1'b0;
            tx_word  <= '0;
            rx_shift <= '0;
            mode_l   <= '0;
            word_l   <= '0;
            div_l    <= '0;
            bit_idx  <= '0;
            half_cnt <= '0;
        end else begin
            TxRead  <= 1'b0;
            RxWrite <= 1'b0;
            if (ClearOV) begin
                RxOV <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (Enable && !TxEmpty) begin
                        state  <= FETCH;
                        TxRead <= 1'b1;
                        Busy   <= 1'b1;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    tx_word           <= TxData;
                    mode_l[MODE_CPOL] <= Cpol;
                    mode_l[MODE_CPHA] <= Cpha;
                    word_l            <= WordSize;
                    div_l             <= BaudDiv;
                    rx_shift          <= '0;
                    half_cnt          <= '0;
                    phase             <= 1'b0;
                    CS_n              <= 1'b0;
                    state             <= SHIFT;
                    // CPHA=0 presents the MSB as CS falls; CPHA=1 waits for the first edge.
                    if (!Cpha) begin
                        MOSI    <= TxData[WordSize];
                        bit_idx <= WordSize - 5'd1;
                    end else begin
                        bit_idx <= WordSize;
                    end
                end
                SHIFT: begin
                    if (half_tick) begin
                        if (half_cnt == last_idx) begin
                            state   <= DONE;
                            CS_n    <= 1'b1;
                            RxData  <= rx_shift;
                            RxWrite <= !RxFull;
                            if (RxFull) begin
                                RxOV <= 1'b1;
                            end
                        end else begin
                            phase    <= ~phase;
                            half_cnt <= half_cnt + 7'd1;
                            if (odd_edge == mode_l[MODE_CPHA]) begin
                                MOSI    <= tx_word[bit_idx];
                                bit_idx <= bit_idx - 5'd1;
                            end else begin
                                rx_shift <= {rx_shift[FIFOWIDTH-2:0], MISO};
                            end
                            // The CPHA=0 trailing edge of the last bit must not advance MOSI.
                            if (!mode_l[MODE_CPHA] && (half_cnt + 7'd1 == last_idx)) begin
                                MOSI    <= MOSI;
                                bit_idx <= bit_idx;
                            end
                        end
                    end
                end
                DONE: state <= GAP;
                GAP: begin
                    if (half_tick) begin
                        if (Enable && !TxEmpty) begin
                            state  <= FETCH;
                            TxRead <= 1'b1;
                        end else begin
                            state <= IDLE;
                            Busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed testbench for spi_shift_engine with MISO looped back to MOSI and a
// small TX FIFO model feeding registered DataOut.
module tb_spi_shift_engine;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Enable;
    logic        Cpol;
    logic        Cpha;
    logic [4:0]  WordSize;
    logic [7:0]  BaudDiv;
    logic        TxEmpty;
    logic [31:0] TxData = '0;
    logic        TxRead;
    logic        RxFull;
    logic [31:0] RxData;
    logic        RxWrite;
    logic        ClearOV;
    logic        RxOV;
    logic        SCLK;
    logic        MOSI;
    logic        MISO;
    logic        CS_n;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] tx_mem [16];
    int          tx_wr = 0;
    int          tx_rd = 0;

    int          sclk_edges = 0;
    int          sclk_rises = 0;
    int          rxw_cnt    = 0;
    int          txr_cnt    = 0;
    int          cs_low_cyc = 0;
    int          busy_cyc   = 0;
    int          gap_n      = 0;
    int          high_run   = 0;
    int          gaps [64];
    logic [31:0] rx_log [16];
    logic [31:0] last_rx    = '0;
    logic        prev_cs    = 1'b1;
    logic        first_mosi = 1'b0;

    spi_shift_engine #(
        .FIFOWIDTH(32),
        .DIVWIDTH (8)
    ) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .Cpol    (Cpol),
        .Cpha    (Cpha),
        .WordSize(WordSize),
        .BaudDiv (BaudDiv),
        .TxEmpty (TxEmpty),
        .TxData  (TxData),
        .TxRead  (TxRead),
        .RxFull  (RxFull),
        .RxData  (RxData),
        .RxWrite (RxWrite),
        .ClearOV (ClearOV),
        .RxOV    (RxOV),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .CS_n    (CS_n),
        .Busy    (Busy)
    );

    always #5 Clock = ~Clock;

    assign MISO    = MOSI;
    assign TxEmpty = (tx_rd == tx_wr);

    // TX FIFO model: DataOut is registered and updates on the pop edge.
    always @(posedge Clock) begin
        if (TxRead === 1'b1 && tx_rd != tx_wr) begin
            TxData <= tx_mem[tx_rd % 16];
            tx_rd  <= tx_rd + 1;
        end
    end

    always @(SCLK) sclk_edges++;
    always @(posedge SCLK) sclk_rises++;

    // Cumulative activity counters; tests compare differences across a transfer.
    always @(negedge Clock) begin
        if (RxWrite === 1'b1) begin
            rx_log[rxw_cnt % 16] = RxData;
            rxw_cnt++;
            last_rx = RxData;
        end
        if (TxRead === 1'b1) txr_cnt++;
        if (Busy === 1'b1) busy_cyc++;
        if (CS_n === 1'b0) begin
            cs_low_cyc++;
            if (prev_cs === 1'b1) begin
                gaps[gap_n % 64] = high_run;
                gap_n++;
                high_run = 0;
                first_mosi = MOSI;
            end
        end else begin
            high_run++;
        end
        prev_cs = CS_n;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired: simulation did not finish, got hang, want completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic push_word(input logic [31:0] w);
        tx_mem[tx_wr % 16] = w;
        tx_wr = tx_wr + 1;
    endtask

    task automatic configure(input logic pol, input logic pha, input logic [4:0] ws, input logic [7:0] div);
        Cpol     = pol;
        Cpha     = pha;
        WordSize = ws;
        BaudDiv  = div;
    endtask

    task automatic run_until_idle(output bit timed_out);
        int n;
        timed_out = 1'b0;
        n = 0;
        while (Busy !== 1'b1 && n < 100) begin
            @(negedge Clock);
            n++;
        end
        if (Busy !== 1'b1) timed_out = 1'b1;
        n = 0;
        while (Busy !== 1'b0 && n < 20000) begin
            @(negedge Clock);
            n++;
        end
        if (Busy !== 1'b0) timed_out = 1'b1;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_reset;
        Reset   = 1'b0;
        Enable  = 1'b0;
        RxFull  = 1'b0;
        ClearOV = 1'b0;
        configure(1'b0, 1'b0, 5'd7, 8'd1);
        repeat (3) @(negedge Clock);
        checks++; if (CS_n !== 1'b1) begin failures++; $display("[TB] FAIL reset_cs_n got %b want 1", CS_n); end
        checks++; if (SCLK !== 1'b0) begin failures++; $display("[TB] FAIL reset_sclk got %b want 0", SCLK); end
        checks++; if (MOSI !== 1'b0) begin failures++; $display("[TB] FAIL reset_mosi got %b want 0", MOSI); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", Busy); end
        checks++; if (TxRead !== 1'b0 || RxWrite !== 1'b0) begin failures++; $display("[TB] FAIL reset_strobes got %b%b want 00", TxRead, RxWrite); end
        checks++; if (RxData !== 32'h0) begin failures++; $display("[TB] FAIL reset_rxdata got %h want 00000000", RxData); end
        checks++; if (RxOV !== 1'b0) begin failures++; $display("[TB] FAIL reset_rxov got %b want 0", RxOV); end
        Reset = 1'b1;
        repeat (2) @(negedge Clock);
    endtask

    task automatic test_mode0_loopback;
        int b_rise, b_cs, b_rxw, b_txr, b_busy;
        bit to;
        configure(1'b0, 1'b0, 5'd7, 8'd1);
        b_rise = sclk_rises; b_cs = cs_low_cyc; b_rxw = rxw_cnt; b_txr = txr_cnt; b_busy = busy_cyc;
        push_word(32'h0000_00A5);
        Enable = 1'b1;
        run_until_idle(to);
        Enable = 1'b0;
        checks++; if (to) begin failures++; $display("[TB] FAIL mode0_timeout got timeout want idle"); end
        checks++; if (sclk_rises - b_rise !== 8) begin failures++; $display("[TB] FAIL mode0_sclk_rises got %0d want 8", sclk_rises - b_rise); end
        checks++; if (first_mosi !== 1'b1) begin failures++; $display("[TB] FAIL mode0_first_mosi got %b want 1", first_mosi); end
        checks++; if (cs_low_cyc - b_cs !== 34) begin failures++; $display("[TB] FAIL mode0_cs_low got %0d want 34", cs_low_cyc - b_cs); end
        checks++; if (rxw_cnt - b_rxw !== 1) begin failures++; $display("[TB] FAIL mode0_rxwrites got %0d want 1", rxw_cnt - b_rxw); end
        checks++; if (last_rx !== 32'h0000_00A5) begin failures++; $display("[TB] FAIL mode0_rxdata got %h want 000000a5", last_rx); end
        checks++; if (txr_cnt - b_txr !== 1) begin failures++; $display("[TB] FAIL mode0_txreads got %0d want 1", txr_cnt - b_txr); end
        checks++; if (busy_cyc - b_busy !== 39) begin failures++; $display("[TB] FAIL mode0_busy_cycles got %0d want 39", busy_cyc - b_busy); end
    endtask

    task automatic test_mode3_full_word;
        int b_rise, b_cs, b_rxw;
        bit to;
        configure(1'b1, 1'b1, 5'd31, 8'd0);
        #1;
        checks++; if (SCLK !== 1'b1) begin failures++; $display("[TB] FAIL mode3_sclk_idle got %b want 1", SCLK); end
        @(negedge Clock);
        b_rise = sclk_rises; b_cs = cs_low_cyc; b_rxw = rxw_cnt;
        push_word(32'hDEAD_BEEF);
        Enable = 1'b1;
        run_until_idle(to);
        Enable = 1'b0;
        checks++; if (to) begin failures++; $display("[TB] FAIL mode3_timeout got timeout want idle"); end
        checks++; if (sclk_rises - b_rise !== 32) begin failures++; $display("[TB] FAIL mode3_sclk_rises got %0d want 32", sclk_rises - b_rise); end
        checks++; if (cs_low_cyc - b_cs !== 65) begin failures++; $display("[TB] FAIL mode3_cs_low got %0d want 65", cs_low_cyc - b_cs); end
        checks++; if (rxw_cnt - b_rxw !== 1) begin failures++; $display("[TB] FAIL mode3_rxwrites got %0d want 1", rxw_cnt - b_rxw); end
        checks++; if (last_rx !== 32'hDEAD_BEEF) begin failures++; $display("[TB] FAIL mode3_rxdata got %h want deadbeef", last_rx); end
        checks++; if (SCLK !== 1'b1) begin failures++; $display("[TB] FAIL mode3_sclk_after got %b want 1", SCLK); end
    endtask

    task automatic test_single_bit;
        int b_cs;
        bit to;
        configure(1'b0, 1'b0, 5'd0, 8'd0);
        @(negedge Clock);
        b_cs = cs_low_cyc;
        push_word(32'hFFFF_FFFF);
        Enable = 1'b1;
        run_until_idle(to);
        Enable = 1'b0;
        checks++; if (to) begin failures++; $display("[TB] FAIL single_timeout got timeout want idle"); end
        checks++; if (cs_low_cyc - b_cs !== 3) begin failures++; $display("[TB] FAIL single_cs_low got %0d want 3", cs_low_cyc - b_cs); end
        checks++; if (last_rx !== 32'h0000_0001) begin failures++; $display("[TB] FAIL single_rxdata got %h want 00000001", last_rx); end
    endtask

    task automatic test_back_to_back;
        int b_rxw, b_txr, b_busy, b_gap;
        bit to;
        configure(1'b0, 1'b0, 5'd7, 8'd2);
        b_rxw = rxw_cnt; b_txr = txr_cnt; b_busy = busy_cyc; b_gap = gap_n;
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        Enable = 1'b1;
        run_until_idle(to);
        Enable = 1'b0;
        checks++; if (to) begin failures++; $display("[TB] FAIL b2b_timeout got timeout want idle"); end
        checks++; if (txr_cnt - b_txr !== 3) begin failures++; $display("[TB] FAIL b2b_txreads got %0d want 3", txr_cnt - b_txr); end
        checks++; if (rxw_cnt - b_rxw !== 3) begin failures++; $display("[TB] FAIL b2b_rxwrites got %0d want 3", rxw_cnt - b_rxw); end
        checks++; if (rx_log[b_rxw % 16] !== 32'h11 || rx_log[(b_rxw + 1) % 16] !== 32'h22 || rx_log[(b_rxw + 2) % 16] !== 32'h33)
            begin failures++; $display("[TB] FAIL b2b_rxdata got %h %h %h want 11 22 33", rx_log[b_rxw % 16], rx_log[(b_rxw + 1) % 16], rx_log[(b_rxw + 2) % 16]); end
        // CS_n high between words spans DONE, the H-cycle GAP, FETCH and LOAD.
        checks++; if (gaps[(b_gap + 1) % 64] !== 6 || gaps[(b_gap + 2) % 64] !== 6)
            begin failures++; $display("[TB] FAIL b2b_cs_gap got %0d,%0d want 6,6", gaps[(b_gap + 1) % 64], gaps[(b_gap + 2) % 64]); end
        checks++; if (busy_cyc - b_busy !== 171) begin failures++; $display("[TB] FAIL b2b_busy_cycles got %0d want 171", busy_cyc - b_busy); end
    endtask

    task automatic test_overflow;
        int b_rxw, n;
        bit to;
        configure(1'b0, 1'b0, 5'd7, 8'd0);
        RxFull = 1'b1;
        b_rxw = rxw_cnt;
        push_word(32'h3C);
        Enable = 1'b1;
        run_until_idle(to);
        checks++; if (to) begin failures++; $display("[TB] FAIL ov_timeout got timeout want idle"); end
        checks++; if (rxw_cnt - b_rxw !== 0) begin failures++; $display("[TB] FAIL ov_rxwrites got %0d want 0", rxw_cnt - b_rxw); end
        checks++; if (RxOV !== 1'b1) begin failures++; $display("[TB] FAIL ov_set got %b want 1", RxOV); end
        repeat (5) @(negedge Clock);
        checks++; if (RxOV !== 1'b1) begin failures++; $display("[TB] FAIL ov_sticky got %b want 1", RxOV); end
        ClearOV = 1'b1;
        @(negedge Clock);
        ClearOV = 1'b0;
        checks++; if (RxOV !== 1'b0) begin failures++; $display("[TB] FAIL ov_clear got %b want 0", RxOV); end
        ClearOV = 1'b1;
        push_word(32'h7E);
        n = 0;
        while (CS_n !== 1'b0 && n < 100) begin @(negedge Clock); n++; end
        checks++; if (CS_n !== 1'b0) begin failures++; $display("[TB] FAIL ov_cs_fall got %b want 0", CS_n); end
        checks++; if (RxOV !== 1'b0) begin failures++; $display("[TB] FAIL ov_held_clear got %b want 0", RxOV); end
        n = 0;
        while (CS_n !== 1'b1 && n < 200) begin @(negedge Clock); n++; end
        ClearOV = 1'b0;
        checks++; if (RxOV !== 1'b1) begin failures++; $display("[TB] FAIL ov_set_wins got %b want 1", RxOV); end
        run_until_idle(to);
        Enable = 1'b0;
        checks++; if (rxw_cnt - b_rxw !== 0) begin failures++; $display("[TB] FAIL ov_rxwrites2 got %0d want 0", rxw_cnt - b_rxw); end
        RxFull  = 1'b0;
        ClearOV = 1'b1;
        @(negedge Clock);
        ClearOV = 1'b0;
    endtask

    task automatic test_enable_drop;
        int b_edges, b_rxw, b_txr, n;
        bit to;
        configure(1'b0, 1'b0, 5'd7, 8'd1);
        b_edges = sclk_edges; b_rxw = rxw_cnt; b_txr = txr_cnt;
        push_word(32'h5A);
        push_word(32'h96);
        Enable = 1'b1;
        n = 0;
        while (sclk_edges - b_edges < 3 && n < 200) begin @(negedge Clock); n++; end
        Enable = 1'b0;
        run_until_idle(to);
        checks++; if (to) begin failures++; $display("[TB] FAIL drop_timeout got timeout want idle"); end
        checks++; if (sclk_edges - b_edges !== 16) begin failures++; $display("[TB] FAIL drop_sclk_edges got %0d want 16", sclk_edges - b_edges); end
        checks++; if (rxw_cnt - b_rxw !== 1 || last_rx !== 32'h5A) begin failures++; $display("[TB] FAIL drop_rx got %0d writes data %h want 1 writes data 0000005a", rxw_cnt - b_rxw, last_rx); end
        checks++; if (txr_cnt - b_txr !== 1) begin failures++; $display("[TB] FAIL drop_txreads got %0d want 1", txr_cnt - b_txr); end
        checks++; if (TxEmpty !== 1'b0 || Busy !== 1'b0) begin failures++; $display("[TB] FAIL drop_idle got empty=%b busy=%b want empty=0 busy=0", TxEmpty, Busy); end
    endtask

    task automatic test_reset_midword;
        int b_edges, b_rxw, b_cs, n;
        bit to;
        configure(1'b0, 1'b0, 5'd7, 8'd1);
        push_word(32'hC3);
        b_edges = sclk_edges; b_rxw = rxw_cnt;
        Enable = 1'b1;
        n = 0;
        while (sclk_edges - b_edges < 5 && n < 200) begin @(negedge Clock); n++; end
        Reset = 1'b0;
        #1;
        checks++; if (CS_n !== 1'b1 || SCLK !== 1'b0) begin failures++; $display("[TB] FAIL rst_abort got cs_n=%b sclk=%b want cs_n=1 sclk=0", CS_n, SCLK); end
        checks++; if (Busy !== 1'b0 || MOSI !== 1'b0) begin failures++; $display("[TB] FAIL rst_abort_state got busy=%b mosi=%b want 0 0", Busy, MOSI); end
        repeat (3) @(negedge Clock);
        checks++; if (rxw_cnt - b_rxw !== 0) begin failures++; $display("[TB] FAIL rst_no_rxwrite got %0d want 0", rxw_cnt - b_rxw); end
        b_cs = cs_low_cyc;
        Reset = 1'b1;
        run_until_idle(to);
        Enable = 1'b0;
        checks++; if (to) begin failures++; $display("[TB] FAIL rst_timeout got timeout want idle"); end
        checks++; if (rxw_cnt - b_rxw !== 1 || last_rx !== 32'hC3) begin failures++; $display("[TB] FAIL rst_next_word got %0d writes data %h want 1 writes data 000000c3", rxw_cnt - b_rxw, last_rx); end
        checks++; if (cs_low_cyc - b_cs !== 34) begin failures++; $display("[TB] FAIL rst_next_cs_low got %0d want 34", cs_low_cyc - b_cs); end
        checks++; if (TxEmpty !== 1'b1) begin failures++; $display("[TB] FAIL rst_fifo_drained got %b want 1", TxEmpty); end
    endtask

    initial begin
        test_reset();
        test_mode0_loopback();
        test_mode3_full_word();
        test_single_bit();
        test_back_to_back();
        test_overflow();
        test_enable_drop();
        test_reset_midword();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
